// File: rtl/bulk_ep_in_pkt.sv
// Packet-aware bulk IN endpoint buffer: slices an AXI-Stream byte source into USB packets,
// holds each packet until ACK and rewinds on retry. Define BULK_EP_IN_ZLP_EN for ZLP termination.
module bulk_ep_in_pkt #(
  parameter int ABITS   = 11,
  parameter int MAX_PKT = 512
) (
  input  logic             axis_aclk,
  input  logic             reset_n,
  input  logic             s_tvalid_i,
  output logic             s_tready_o,
  input  logic             s_tlast_i,
  input  logic [7:0]       s_tdata_i,
  input  logic             ep_xfer_i,
  input  logic             ep_ack_i,
  output logic             ep_has_data_o,
  output logic             ep_tvalid_o,
  input  logic             ep_tready_i,
  output logic             ep_tlast_o,
  output logic             ep_tkeep_o,
  output logic [7:0]       ep_tdata_o,
  output logic [ABITS:0]   level_o
);
  localparam int AW    = ABITS + 1;
  localparam int CW    = $clog2(MAX_PKT + 1);
  localparam int DEPTH = 1 << ABITS;
  localparam logic [AW-1:0] DEPTH_W   = AW'(DEPTH);
  localparam logic [AW-1:0] MAX_PKT_W = AW'(MAX_PKT);
  localparam logic [CW-1:0] MAX_PKT_C = CW'(MAX_PKT);
`ifdef BULK_EP_IN_ZLP_EN
  localparam logic ZLP_EN = 1'b1;
`else
  localparam logic ZLP_EN = 1'b0;
`endif

  if (MAX_PKT > DEPTH || MAX_PKT < 8 || MAX_PKT > 1024) begin : g_bad_cfg
    $error("bulk_ep_in_pkt: MAX_PKT must be within 8..1024 and not exceed 2**ABITS");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT_ACK = 2'd2} state_e;

  logic [8:0]    mem_q [DEPTH];
  state_e        state_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, cm_ptr_q, frames_q, level_q;
  logic [AW-1:0] wr_ptr_d, cm_ptr_d, frames_d, level_d;
  logic          zlp_q, zlp_d;
  logic [CW-1:0] cnt_q, pkt_len_q;
  logic          pkt_tlast_q, beat_tlast_q, is_zlp_q, xfer_q;
  logic          tvalid_q, tlast_q, tkeep_q, ready_q, has_data_q;
  logic [7:0]    tdata_q;
  logic          wr_en, commit;
  logic [8:0]    rd_word;

  assign wr_en   = s_tvalid_i && ready_q;
  assign commit  = (state_q == WAIT_ACK) && ep_ack_i;
  assign rd_word = mem_q[rd_ptr_q[ABITS-1:0]];

  // Pointer, frame and ZLP bookkeeping; space is only released by a committed ACK.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (wr_en ? AW'(1) : AW'(0));
    cm_ptr_d = commit ? rd_ptr_q : cm_ptr_q;
    frames_d = frames_q + ((wr_en && s_tlast_i) ? AW'(1) : AW'(0))
                        - ((commit && pkt_tlast_q) ? AW'(1) : AW'(0));
    level_d  = wr_ptr_d - cm_ptr_d;
    zlp_d    = zlp_q;
    if (commit) begin
      if (is_zlp_q) begin
        zlp_d = 1'b0;
      end else begin
        zlp_d = ZLP_EN && pkt_tlast_q && (pkt_len_q == MAX_PKT_C);
      end
    end else begin
      zlp_d = zlp_q;
    end
  end

  // Byte storage, {tlast, data} per entry.
  always_ff @(posedge axis_aclk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[ABITS-1:0]] <= {s_tlast_i, s_tdata_i};
    end
  end

  // Registered occupancy state and source-side flags.
  always_ff @(posedge axis_aclk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      cm_ptr_q   <= '0;
      frames_q   <= '0;
      zlp_q      <= 1'b0;
      level_q    <= '0;
      ready_q    <= 1'b0;
      has_data_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      cm_ptr_q   <= cm_ptr_d;
      frames_q   <= frames_d;
      zlp_q      <= zlp_d;
      level_q    <= level_d;
      ready_q    <= (level_d != DEPTH_W);
      has_data_q <= (frames_q != '0) || (level_q >= MAX_PKT_W) || zlp_q;
    end
  end

  // Transaction FSM with speculative read pointer and registered packet beat.
  always_ff @(posedge axis_aclk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      pkt_len_q    <= '0;
      pkt_tlast_q  <= 1'b0;
      beat_tlast_q <= 1'b0;
      is_zlp_q     <= 1'b0;
      xfer_q       <= 1'b0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tkeep_q      <= 1'b1;
      tdata_q      <= 8'h00;
    end else begin
      xfer_q <= ep_xfer_i;
      case (state_q)
        IDLE: begin
          tvalid_q <= 1'b0;
          if (ep_xfer_i && !xfer_q && has_data_q) begin
            state_q  <= SEND;
            cnt_q    <= '0;
            is_zlp_q <= zlp_q;
          end
        end
        SEND: begin
          if (!ep_xfer_i) begin
            rd_ptr_q <= cm_ptr_q;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tkeep_q  <= 1'b1;
            state_q  <= IDLE;
          end else if (!tvalid_q || ep_tready_i) begin
            if (tvalid_q && tlast_q) begin
              tvalid_q    <= 1'b0;
              tlast_q     <= 1'b0;
              tkeep_q     <= 1'b1;
              pkt_len_q   <= cnt_q;
              pkt_tlast_q <= beat_tlast_q;
              state_q     <= WAIT_ACK;
            end else if (is_zlp_q) begin
              tvalid_q     <= 1'b1;
              tlast_q      <= 1'b1;
              tkeep_q      <= 1'b0;
              tdata_q      <= 8'h00;
              beat_tlast_q <= 1'b0;
            end else begin
              tvalid_q     <= 1'b1;
              tdata_q      <= rd_word[7:0];
              beat_tlast_q <= rd_word[8];
              tlast_q      <= rd_word[8] || ((cnt_q + CW'(1)) == MAX_PKT_C);
              tkeep_q      <= 1'b1;
              rd_ptr_q     <= rd_ptr_q + AW'(1);
              cnt_q        <= cnt_q + CW'(1);
            end
          end
        end
        WAIT_ACK: begin
          if (ep_ack_i) begin
            state_q <= IDLE;
          end else if (!ep_xfer_i) begin
            rd_ptr_q <= cm_ptr_q;
            state_q  <= IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          tvalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_tready_o    = ready_q;
  assign ep_has_data_o = has_data_q;
  assign ep_tvalid_o   = tvalid_q;
  assign ep_tlast_o    = tlast_q;
  assign ep_tkeep_o    = ZLP_EN ? tkeep_q : 1'b1;
  assign ep_tdata_o    = tdata_q;
  assign level_o       = level_q;
endmodule

// File: doc/bulk_ep_in_pkt.md
Name: bulk_ep_in_pkt

Overview:
Single-clock, packet-aware bulk IN endpoint buffer. It is the successor to the first-generation bulk IN endpoint and has a parametrised depth and max packet size.
- Accepts an AXI-Stream byte source and slices the stream into USB packets of at most MAX_PKT bytes.
- Holds each packet until the host ACKs it, and rewinds for a retry if the ACK never arrives.
- Optionally appends a zero-length packet (ZLP).
- Sits between the application stream and the USB protocol/packet-encoder layer, which runs on the same clock.

Parameters:
- ABITS, 11, log2 of FIFO depth in bytes (DEPTH = 2**ABITS). MAX_PKT <= DEPTH is enforced by an elaboration-time check.
- MAX_PKT, 512, maximum USB packet payload in bytes (8..1024).

Ports:
- axis_aclk  in  1  clock for all logic.
- reset_n  in  1  synchronous, active-low reset.
- s_tvalid_i  in  1  source byte valid.
- s_tready_o  out  1  source ready.
- s_tlast_i  in  1  last byte of source frame.
- s_tdata_i  in  8  source byte.
- ep_xfer_i  in  1  high for the duration of an IN transaction addressed to this endpoint.
- ep_ack_i  in  1  one-cycle pulse: host ACKed the packet just sent.
- ep_has_data_o  out  1  a sendable packet (or ZLP) is buffered.
- ep_tvalid_o  out  1  packet byte valid.
- ep_tready_i  in  1  encoder ready.
- ep_tlast_o  out  1  last beat of USB packet.
- ep_tkeep_o  out  1  0 only on the ZLP beat.
- ep_tdata_o  out  8  packet byte.
- level_o  out  ABITS+1  bytes held, counted from the committed read pointer.

Behaviour:
- Reset:
  - Pointers, counters, zlp_pending and state are all cleared; state goes to IDLE.
  - Outputs while reset_n is low and on the first cycle after: s_tready_o=0 during reset and 1 from the first cycle after reset; ep_tvalid_o=0, ep_tlast_o=0, ep_tkeep_o=1, ep_has_data_o=0, level_o=0.
  - Reset mid-transaction discards all buffered data.
- Storage:
  - 9-bit entries {tlast, data}.
  - Pointers: wr_ptr, rd_ptr (speculative), cm_ptr (committed). All are ABITS+1 wide and wrap naturally.
  - level = wr_ptr - cm_ptr.
  - s_tready_o = (level != DEPTH). Space is freed only on ACK.
- Frame counter frames (ABITS+1 bits):
  - +1 on a write with tlast.
  - -1 on an ACK of a packet whose final byte carried tlast.
  - A write and an ACK in the same cycle apply both the increment and the decrement.
- ep_has_data_o (registered) = frames!=0 OR level>=MAX_PKT OR zlp_pending.
- State machine:
  - IDLE:
    - ep_xfer_i rising with has_data=1 -> SEND. The packet byte counter is cleared to 0.
    - ep_xfer_i with has_data=0 -> stays IDLE; no output.
  - SEND:
    - ep_tvalid_o asserts 1 cycle after entry.
    - Data is registered; the first byte is prefetched; beats hold stable until ep_tready_i.
    - ep_tlast_o=1 on the beat where the stored tlast=1 or the byte count reaches MAX_PKT.
    - rd_ptr advances per accepted beat.
    - On the accepted tlast beat -> WAIT_ACK, recording pkt_len and whether the packet ended in tlast.
  - WAIT_ACK:
    - ep_ack_i -> cm_ptr<=rd_ptr, update frames/zlp_pending, go to IDLE.
    - ep_xfer_i low without an ACK -> rd_ptr<=cm_ptr (retry), go to IDLE.
  - ep_xfer_i falling during SEND -> abort: rd_ptr<=cm_ptr, ep_tvalid_o<=0, go to IDLE.
  - An ACK outside WAIT_ACK is ignored.
- Writes continue in every state. A write and a commit in the same cycle give level = level + 1 - pkt_len.
- If a packet exactly fills MAX_PKT without tlast, the next packet continues the same frame.

Optional Feature:
- Macro: BULK_EP_IN_ZLP_EN.
- Defined:
  - An ACKed packet with pkt_len==MAX_PKT that ended in tlast sets zlp_pending.
  - The next IN transaction emits a single beat with ep_tvalid_o=1, ep_tlast_o=1, ep_tkeep_o=0, data 0x00, then enters WAIT_ACK.
  - On ACK, zlp_pending clears; no bytes are consumed.
  - A ZLP takes priority over buffered data of later frames.
- Undefined: zlp_pending is constant 0 and ep_tkeep_o is tied 1.

Test Plan:
- Write a 10-byte frame (tlast on byte 10), then pulse xfer, tready=1 and ACK -> 10 beats with tlast on beat 10; has_data rises 2 cycles after the tlast write; level 10->0 on ACK.
- MAX_PKT=8, 20-byte frame, three IN+ACK transactions -> packets of 8, 8 and 4 bytes; tlast on beats 8, 8, 4; has_data=0 after the third ACK.
- Send an 8-byte packet, drop xfer without ACK, retry -> the identical 8 bytes are resent; level stays 8 until the ACK.
- Fill to DEPTH with no tlast -> s_tready_o=0 at level==DEPTH; ACK of one MAX_PKT packet -> s_tready_o=1 the next cycle, and level equals DEPTH-MAX_PKT plus any concurrent write.
- With BULK_EP_IN_ZLP_EN and MAX_PKT=8, a 16-byte frame -> packets 8 and 8, then a ZLP beat (tkeep=0, tlast=1). Without the macro, there is no third packet and has_data=0.
- Assert reset_n=0 mid-SEND for 1 cycle -> all outputs take their reset values, level_o=0, and the next frame is delivered correctly.
